bloom_line_updater: RTL and testbench

- Sequential read-modify-write engine for one time-sliced Bloom-filter line memory.
- Keeps the epoch timer: current bucket index plus loop counter.
- Each request reads a line, ages it to the current epoch by discarding expired buckets, optionally inserts a mask into the newest bucket, writes the line back and returns a membership result.
- Sits between the hash/lookup stage and the external line SRAM. Parametrised successor of the combinational line-aging logic, with memory sequencing, op modes and wrap-safe epoch arithmetic.

---
 rtl/bloom_pkg.sv | 33 +++
 rtl/bloom_line_age.sv | 78 +++++++
 rtl/bloom_line_updater.sv | 142 ++++++++++++++
 tb/tb_bloom_line_updater.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared definitions for the time-sliced Bloom line engine: op codes and line-field layout.
package bloom_pkg;

  typedef enum logic [1:0] {
    OP_QUERY     = 2'b00,
    OP_INSERT    = 2'b01,
    OP_INS_QUERY = 2'b10,
    OP_AGE       = 2'b11
  } bloom_op_e;

  // Line layout from the LSB: loop stamp, bucket stamp, bloom buckets (oldest lowest).
  localparam int unsigned LOOP_LSB = 0;

  function automatic int unsigned bucket_lsb(input int unsigned loop_bits);
    return LOOP_LSB + loop_bits;
  endfunction

  function automatic int unsigned bloom_lsb(input int unsigned bits_shift,
                                            input int unsigned loop_bits);
    return LOOP_LSB + loop_bits + bits_shift;
  endfunction

  function automatic int unsigned data_width(input int unsigned num_buckets,
                                             input int unsigned bucket_sz,
                                             input int unsigned bits_shift,
                                             input int unsigned loop_bits);
    return num_buckets * bucket_sz + bits_shift + loop_bits;
  endfunction

  localparam int unsigned BUCKET_LSB = bucket_lsb(12);
  localparam int unsigned BLOOM_LSB  = bloom_lsb(4, 12);

endpackage

// File: rtl/bloom_line_age.sv
// Combinational line aging: expires buckets older than the epoch, optionally inserts a mask
// into the newest bucket and reports whether the mask was present before insertion.
module bloom_line_age
  import bloom_pkg::*;
#(
  parameter  int unsigned NUM_BUCKETS = 14,
  parameter  int unsigned BUCKET_SZ   = 4,
  parameter  int unsigned BITS_SHIFT  = 4,
  parameter  int unsigned LOOP_BITS   = 12,
  localparam int unsigned DATA_WIDTH  = data_width(NUM_BUCKETS, BUCKET_SZ, BITS_SHIFT, LOOP_BITS)
) (
  input  logic [DATA_WIDTH-1:0] line_i,
  input  logic [BITS_SHIFT-1:0] cb_i,
  input  logic [LOOP_BITS-1:0]  cl_i,
  input  logic [BUCKET_SZ-1:0]  mask_i,
  input  logic                  insert_i,
  output logic [DATA_WIDTH-1:0] line_o,
  output logic                  hit_o
);

  localparam int unsigned B_LSB   = bucket_lsb(LOOP_BITS);
  localparam int unsigned M_LSB   = bloom_lsb(BITS_SHIFT, LOOP_BITS);
  localparam int unsigned BLOOM_W = NUM_BUCKETS * BUCKET_SZ;
  localparam int unsigned SW      = BITS_SHIFT + 2;

  logic [LOOP_BITS-1:0]  d_loop, dl;
  logic [BITS_SHIFT-1:0] d_bucket;
  logic [BLOOM_W-1:0]    bloom, aged, ins;
  logic [SW-1:0]         base, shift;
  logic [BUCKET_SZ-1:0]  any;
  logic                  keep_stamp, block_ins;

  always_comb begin
    d_loop     = line_i[LOOP_LSB +: LOOP_BITS];
    d_bucket   = line_i[B_LSB +: BITS_SHIFT];
    bloom      = line_i[M_LSB +: BLOOM_W];
    dl         = cl_i - d_loop;
    base       = SW'(NUM_BUCKETS) + SW'(cb_i);
    keep_stamp = 1'b0;
    block_ins  = 1'b0;
    shift      = '0;

    if (dl == '0) begin
      if (cb_i >= d_bucket) shift = SW'(cb_i) - SW'(d_bucket);
      else                  keep_stamp = 1'b1;
    end else if (dl == LOOP_BITS'(1)) begin
      // Previous loop: distance is NUM_BUCKETS-db+cb, clamped to [0, NUM_BUCKETS].
      if (base <= SW'(d_bucket))                         shift = '0;
      else if (base - SW'(d_bucket) >= SW'(NUM_BUCKETS)) shift = SW'(NUM_BUCKETS);
      else                                               shift = base - SW'(d_bucket);
    end else if (dl == '1) begin
      keep_stamp = 1'b1;
      block_ins  = 1'b1;
    end else begin
      shift = SW'(NUM_BUCKETS);
    end

    aged = bloom >> (shift * BUCKET_SZ);

    any = '0;
    for (int unsigned i = 0; i < NUM_BUCKETS; i++) begin
      any |= aged[i*BUCKET_SZ +: BUCKET_SZ];
    end
    hit_o = (mask_i != '0) && ((any & mask_i) == mask_i);

    ins = aged;
    if (insert_i && !block_ins) begin
      ins[(NUM_BUCKETS-1)*BUCKET_SZ +: BUCKET_SZ] =
        aged[(NUM_BUCKETS-1)*BUCKET_SZ +: BUCKET_SZ] | mask_i;
    end

    line_o                          = '0;
    line_o[M_LSB +: BLOOM_W]        = ins;
    line_o[B_LSB +: BITS_SHIFT]     = keep_stamp ? d_bucket : cb_i;
    line_o[LOOP_LSB +: LOOP_BITS]   = keep_stamp ? d_loop : cl_i;
  end

endmodule

// File: rtl/bloom_line_updater.sv
// Read-modify-write engine for one Bloom line memory; owns the epoch timer and sequences
// read, aging/insert, write-back and response for one request at a time.
module bloom_line_updater
  import bloom_pkg::*;
#(
  parameter  int unsigned NUM_BUCKETS = 14,
  parameter  int unsigned BUCKET_SZ   = 4,
  parameter  int unsigned BITS_SHIFT  = 4,
  parameter  int unsigned LOOP_BITS   = 12,
  parameter  int unsigned ADDR_WIDTH  = 19,
  localparam int unsigned DATA_WIDTH  = data_width(NUM_BUCKETS, BUCKET_SZ, BITS_SHIFT, LOOP_BITS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [BUCKET_SZ-1:0]  req_mask,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  mem_rd_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_rd_vld,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_wr_req,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [BITS_SHIFT-1:0] cur_bucket,
  output logic [LOOP_BITS-1:0]  cur_loop
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_UPD, S_WR} state_e;

  state_e                state_q, state_d;
  logic [BITS_SHIFT-1:0] cur_bucket_q, cur_bucket_d, cb_q;
  logic [LOOP_BITS-1:0]  cur_loop_q, cur_loop_d, cl_q;
  bloom_op_e             op_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BUCKET_SZ-1:0]  mask_q;
  logic [DATA_WIDTH-1:0] line_q, wr_data_q, aged_line;
  logic                  hit_q, age_hit, do_insert, do_query;

  assign do_insert = (op_q == OP_INSERT) || (op_q == OP_INS_QUERY);
  assign do_query  = (op_q == OP_QUERY)  || (op_q == OP_INS_QUERY);

  bloom_line_age #(
    .NUM_BUCKETS (NUM_BUCKETS),
    .BUCKET_SZ   (BUCKET_SZ),
    .BITS_SHIFT  (BITS_SHIFT),
    .LOOP_BITS   (LOOP_BITS)
  ) u_age (
    .line_i   (line_q),
    .cb_i     (cb_q),
    .cl_i     (cl_q),
    .mask_i   (mask_q),
    .insert_i (do_insert),
    .line_o   (aged_line),
    .hit_o    (age_hit)
  );

  always_comb begin
    cur_bucket_d = cur_bucket_q;
    cur_loop_d   = cur_loop_q;
    if (tick) begin
      if (cur_bucket_q == BITS_SHIFT'(NUM_BUCKETS - 1)) begin
        cur_bucket_d = '0;
        cur_loop_d   = cur_loop_q + LOOP_BITS'(1);
      end else begin
        cur_bucket_d = cur_bucket_q + BITS_SHIFT'(1);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    resp_valid = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = S_RD;
      end
      S_RD: begin
        mem_rd_req = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT:  if (mem_rd_vld) state_d = S_UPD;
      S_UPD:   state_d = S_WR;
      S_WR: begin
        mem_wr_req = 1'b1;
        resp_valid = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cur_bucket_q <= '0;
      cur_loop_q   <= '0;
      cb_q         <= '0;
      cl_q         <= '0;
      op_q         <= OP_QUERY;
      addr_q       <= '0;
      mask_q       <= '0;
      line_q       <= '0;
      wr_data_q    <= '0;
      hit_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_bucket_q <= cur_bucket_d;
      cur_loop_q   <= cur_loop_d;
      // Snapshot takes the pre-tick epoch when a tick coincides with the accept.
      if (state_q == S_IDLE && req_valid) begin
        op_q   <= bloom_op_e'(req_op);
        addr_q <= req_addr;
        mask_q <= req_mask;
        cb_q   <= cur_bucket_q;
        cl_q   <= cur_loop_q;
      end
      if (state_q == S_WAIT && mem_rd_vld) line_q <= mem_rd_data;
      if (state_q == S_UPD) begin
        wr_data_q <= aged_line;
        hit_q     <= age_hit && do_query;
      end
    end
  end

  assign resp_hit    = hit_q;
  assign resp_addr   = addr_q;
  assign mem_addr    = addr_q;
  assign mem_wr_data = wr_data_q;
  assign cur_bucket  = cur_bucket_q;
  assign cur_loop    = cur_loop_q;

endmodule

// File: tb/tb_bloom_line_updater.sv
// Directed plus randomized bench for bloom_line_updater with a bucket-array reference model.
module tb_bloom_line_updater;

  localparam logic [18:0] BASE = 19'h4A5F0;

  logic        clk, reset_n, tick, req_valid, req_ready;
  logic [1:0]  req_op;
  logic [18:0] req_addr, resp_addr, mem_addr;
  logic [3:0]  req_mask;
  logic        resp_valid, resp_hit, mem_rd_req, mem_rd_vld, mem_wr_req;
  logic [71:0] mem_rd_data, mem_wr_data;
  logic [3:0]  cur_bucket;
  logic [11:0] cur_loop;

  logic [71:0] a_line, a_out;
  logic [3:0]  a_cb, a_mask;
  logic [11:0] a_cl;
  logic        a_ins, a_hit;

  int          n_checks = 0;
  int          n_errors = 0;
  int          wr_cnt = 0, resp_cnt = 0;
  int          ecb = 0, ecl = 0;
  int          w0, r0;
  logic [71:0] mem [8];
  logic [71:0] last_wr;
  logic        last_hit;

  bloom_line_updater #(
    .NUM_BUCKETS (14),
    .BUCKET_SZ   (4),
    .BITS_SHIFT  (4),
    .LOOP_BITS   (12),
    .ADDR_WIDTH  (19)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tick        (tick),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_addr    (req_addr),
    .req_mask    (req_mask),
    .resp_valid  (resp_valid),
    .resp_hit    (resp_hit),
    .resp_addr   (resp_addr),
    .mem_rd_req  (mem_rd_req),
    .mem_addr    (mem_addr),
    .mem_rd_vld  (mem_rd_vld),
    .mem_rd_data (mem_rd_data),
    .mem_wr_req  (mem_wr_req),
    .mem_wr_data (mem_wr_data),
    .cur_bucket  (cur_bucket),
    .cur_loop    (cur_loop)
  );

  bloom_line_age #(
    .NUM_BUCKETS (14),
    .BUCKET_SZ   (4),
    .BITS_SHIFT  (4),
    .LOOP_BITS   (12)
  ) u_age_unit (
    .line_i   (a_line),
    .cb_i     (a_cb),
    .cl_i     (a_cl),
    .mask_i   (a_mask),
    .insert_i (a_ins),
    .line_o   (a_out),
    .hit_o    (a_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wr_req === 1'b1) wr_cnt++;
    if (resp_valid === 1'b1) resp_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk_line(input logic [55:0] b, input int db, input int dloop);
    return {b, 4'(db), 12'(dloop)};
  endfunction

  // Reference: treat the line as 14 buckets and age by the epoch distance rules.
  function automatic void model(input logic [71:0] line, input int cb, input int cl,
                                input int op, input logic [3:0] mask,
                                output logic [71:0] out, output logic hit);
    int db, dloop, dl, sh;
    bit keep, noins;
    logic [3:0] bk [14];
    logic [3:0] aged [14];
    logic [3:0] orv;
    dloop = int'(line[11:0]);
    db    = int'(line[15:12]);
    for (int i = 0; i < 14; i++) bk[i] = line[16+4*i +: 4];
    dl    = (cl - dloop + 4096) % 4096;
    keep  = 0;
    noins = 0;
    sh    = 14;
    if (dl == 0) begin
      if (cb >= db) sh = cb - db;
      else begin sh = 0; keep = 1; end
    end else if (dl == 1) begin
      sh = 14 - db + cb;
      if (sh > 14) sh = 14;
      if (sh < 0) sh = 0;
    end else if (dl == 4095) begin
      sh = 0; keep = 1; noins = 1;
    end
    orv = 4'h0;
    for (int i = 0; i < 14; i++) begin
      aged[i] = (i + sh < 14) ? bk[i+sh] : 4'h0;
      orv |= aged[i];
    end
    hit = (op == 0 || op == 2) && (mask != 4'h0) && ((orv & mask) == mask);
    if ((op == 1 || op == 2) && !noins) aged[13] = aged[13] | mask;
    out[15:12] = keep ? line[15:12] : 4'(cb);
    out[11:0]  = keep ? line[11:0]  : 12'(cl);
    for (int i = 0; i < 14; i++) out[16+4*i +: 4] = aged[i];
  endfunction

  task automatic epoch_adv();
    ecb++;
    if (ecb == 14) begin
      ecb = 0;
      ecl = (ecl + 1) % 4096;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tick = 1'b1;
      epoch_adv();
    end
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic check_epoch(input string tag);
    check({tag, "_bucket"}, 72'(cur_bucket), 72'(ecb));
    check({tag, "_loop"},   72'(cur_loop),   72'(ecl));
  endtask

  task automatic do_req(input int op, input int idx, input logic [3:0] mask,
                        input int lat, input bit tk);
    logic [71:0] exp_line;
    logic        exp_hit;
    logic [18:0] addr;
    int          wb, rb;
    bit          busy_bad, got;
    addr = BASE | 19'(idx);
    model(mem[idx], ecb, ecl, op, mask, exp_line, exp_hit);
    @(negedge clk);
    check("ready_idle", 72'(req_ready), 72'(1));
    wb        = wr_cnt;
    rb        = resp_cnt;
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_addr  = addr;
    req_mask  = mask;
    tick      = tk;
    if (tk) epoch_adv();
    @(negedge clk);
    req_valid = 1'b0;
    tick      = 1'b0;
    check("rd_strobe", 72'(mem_rd_req), 72'(1));
    check("rd_addr", 72'(mem_addr), 72'(addr));
    busy_bad = 0;
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || mem_wr_req !== 1'b0 || mem_rd_req !== 1'b0) busy_bad = 1;
      if (i == lat) begin
        mem_rd_vld  = 1'b1;
        mem_rd_data = mem[idx];
      end
    end
    @(negedge clk);
    mem_rd_vld  = 1'b0;
    mem_rd_data = 72'(mk_line(56'({$urandom, $urandom}), 15, 0));
    if (req_ready !== 1'b0) busy_bad = 1;
    got = 0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) got = 1;
      else if (req_ready !== 1'b0) busy_bad = 1;
    end
    check("resp_seen", 72'(got), 72'(1));
    last_wr  = 'x;
    last_hit = 1'bx;
    if (got) begin
      last_wr  = mem_wr_data;
      last_hit = resp_hit;
      check("wr_strobe", 72'(mem_wr_req), 72'(1));
      check("wr_data", mem_wr_data, exp_line);
      check("wr_addr", 72'(mem_addr), 72'(addr));
      check("resp_hit", 72'(resp_hit), 72'(exp_hit));
      check("resp_addr", 72'(resp_addr), 72'(addr));
    end
    mem[idx] = exp_line;
    @(negedge clk);
    check("ready_after", 72'(req_ready), 72'(1));
    check("busy_hold", 72'(busy_bad), 72'(0));
    check("wr_count", 72'(wr_cnt - wb), 72'(1));
    check("resp_count", 72'(resp_cnt - rb), 72'(1));
  endtask

  initial begin
    reset_n     = 1'b0;
    tick        = 1'b0;
    req_valid   = 1'b0;
    req_op      = 2'b00;
    req_addr    = '0;
    req_mask    = '0;
    mem_rd_vld  = 1'b0;
    mem_rd_data = '0;
    for (int i = 0; i < 8; i++) mem[i] = '0;

    repeat (2) @(negedge clk);
    check("rst_ready", 72'(req_ready), 72'(1));
    check("rst_resp_valid", 72'(resp_valid), 72'(0));
    check("rst_rd_req", 72'(mem_rd_req), 72'(0));
    check("rst_wr_req", 72'(mem_wr_req), 72'(0));
    check("rst_hit", 72'(resp_hit), 72'(0));
    check("rst_mem_addr", 72'(mem_addr), 72'(0));
    check("rst_wr_data", mem_wr_data, 72'(0));
    check("rst_resp_addr", 72'(resp_addr), 72'(0));
    check_epoch("rst");
    reset_n = 1'b1;

    // Loop wrap: line from loop 4095 seen at epoch (0,0) ages by one bucket.
    mem[1] = 72'hFFFFFFFFFFFFFF_D_FFF;
    do_req(0, 1, 4'h8, 2, 0);
    check("wrap_line", last_wr, 72'h0FFFFFFFFFFFFF_0_000);
    check("wrap_hit", 72'(last_hit), 72'(1));

    ticks(3);
    check_epoch("ep_3_0");
    do_req(1, 0, 4'h5, 1, 0);
    check("ins_line", last_wr, 72'h50000000000000_3_000);
    do_req(0, 0, 4'h5, 9, 0);
    check("query_hit", 72'(last_hit), 72'(1));
    do_req(0, 0, 4'h7, 3, 0);
    check("query_miss", 72'(last_hit), 72'(0));

    do_req(1, 2, 4'hA, 2, 1);
    check("tick_accept_line", last_wr, 72'hA0000000000000_3_000);
    check_epoch("ep_4_0");

    ticks(10);
    check_epoch("ep_14_ticks");

    ticks(62);
    check_epoch("ep_6_5");
    mem[3] = mk_line(56'hFFFFFFFFFFFFFF, 2, 5);
    do_req(0, 3, 4'h1, 4, 0);
    check("shift4_line", last_wr, 72'h0000FFFFFFFFFF_6_005);
    check("shift4_hit", 72'(last_hit), 72'(1));

    ticks(11);
    mem[4] = mk_line(56'hFFFFFFFFFFFFFF, 10, 5);
    do_req(0, 4, 4'hF, 1, 0);
    check("shift7_line", last_wr, 72'h0000000FFFFFFF_3_006);

    ticks(9);
    check_epoch("ep_12_6");
    mem[5] = mk_line(56'hFFFFFFFFFFFFFF, 10, 5);
    do_req(0, 5, 4'h1, 5, 0);
    check("shift14_line", last_wr, 72'h00000000000000_C_006);
    check("shift14_hit", 72'(last_hit), 72'(0));

    mem[6] = mk_line(56'h123456789ABCDE, 0, 7);
    do_req(2, 6, 4'h3, 2, 0);
    check("future_line", last_wr, 72'h123456789ABCDE_0_007);
    check("future_hit", 72'(last_hit), 72'(1));

    // Reset while waiting for read data; the late read must be ignored.
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = BASE | 19'(7);
    req_mask  = 4'hF;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    w0 = wr_cnt;
    r0 = resp_cnt;
    check("abort_busy", 72'(req_ready), 72'(0));
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    ecb = 0;
    ecl = 0;
    mem_rd_vld  = 1'b1;
    mem_rd_data = mem[7];
    @(negedge clk);
    mem_rd_vld = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_wr_count", 72'(wr_cnt - w0), 72'(0));
    check("abort_resp_count", 72'(resp_cnt - r0), 72'(0));
    check("abort_ready", 72'(req_ready), 72'(1));
    check_epoch("abort");

    for (int i = 0; i < 8; i++) begin
      mem[i] = mk_line(56'({$urandom, $urandom}), int'($urandom_range(0, 13)),
                       (ecl + 4096 + 1 - int'($urandom_range(0, 3))) % 4096);
    end
    for (int n = 0; n < 40; n++) begin
      ticks((n % 8 == 7) ? 30 : int'($urandom_range(0, 5)));
      do_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 4'($urandom),
             int'($urandom_range(1, 6)), 1'($urandom));
      if (n % 10 == 9) check_epoch("rand_epoch");
    end

    a_line = mk_line(56'h123456789ABCDE, 5, 0);
    a_cl   = 12'hFFF;
    a_cb   = 4'd2;
    a_mask = 4'hF;
    a_ins  = 1'b1;
    #1;
    check("unit_future_line", a_out, 72'h123456789ABCDE_5_000);

    for (int n = 0; n < 150; n++) begin
      int k, cl;
      logic [71:0] el;
      logic eh;
      cl = int'($urandom_range(0, 4095));
      case ($urandom_range(0, 3))
        0:       k = 0;
        1:       k = 1;
        2:       k = 4095;
        default: k = int'($urandom_range(2, 4094));
      endcase
      a_cl   = 12'(cl);
      a_cb   = 4'($urandom_range(0, 13));
      a_line = mk_line(56'({$urandom, $urandom}), int'($urandom_range(0, 13)),
                       (cl - k + 4096) % 4096);
      a_mask = 4'($urandom);
      a_ins  = 1'($urandom);
      #1;
      model(a_line, int'(a_cb), cl, a_ins ? 2 : 0, a_mask, el, eh);
      check("unit_line", a_out, el);
      check("unit_hit", 72'(a_hit), 72'(eh));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
